// File: rtl/tea_pkg.sv
// Shared TEA definitions: key schedule constant, controller state encoding, mix function.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD_KEY = 4'd1,
    ST_RD_V0_A  = 4'd2,
    ST_RD_V0_D  = 4'd3,
    ST_RD_V1_A  = 4'd4,
    ST_RD_V1_D  = 4'd5,
    ST_HALF_A   = 4'd6,
    ST_HALF_B   = 4'd7,
    ST_WR_V0    = 4'd8,
    ST_WR_V1    = 4'd9,
    ST_DONE     = 4'd10
  } tea_state_e;

  // TEA Feistel mix; shifts are logical, adds wrap mod 2^32
  function automatic logic [31:0] tea_mix(input logic [31:0] v,
                                          input logic [31:0] sum,
                                          input logic [31:0] ka,
                                          input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_half_round.sv
// One TEA half-round: v_upd +/- tea_mix(v_src, sum, ka, kb).
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
module tea_half_round
  import tea_pkg::*;
(
  input  logic [31:0] v_upd_i,
  input  logic [31:0] v_src_i,
  input  logic [31:0] sum_i,
  input  logic [31:0] ka_i,
  input  logic [31:0] kb_i,
  input  logic        sub_i,
  output logic [31:0] v_new_o
);

  logic [31:0] mix;

  // Add for encrypt, subtract for decrypt
  always_comb begin
    mix     = tea_mix(v_src_i, sum_i, ka_i, kb_i);
    v_new_o = sub_i ? (v_upd_i - mix) : (v_upd_i + mix);
  end

endmodule

// File: rtl/tea_ctrl.sv
// Sequencer for one TEA block op: key load, read v0/v1, ROUNDS cycles, write v0/v1 back.
// Latency: 71 cycles from iKeyDone seen to oDone at ROUNDS=32 (4 rd + 2*ROUNDS + 2 wr + 1).
// Backpressure: none; waits on iKeyDone only, iStart low aborts from any state.
module tea_ctrl
  import tea_pkg::*;
#(
  parameter int          WORD_SIZE  = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          ROUNDS     = 32,
  parameter logic [31:0] DELTA      = TEA_DELTA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iStart,
  input  logic                  iDecrypt,
  input  logic [ADDR_WIDTH-1:0] iBase_addr,
  output logic                  oKeyStart,
  input  logic                  iKeyDone,
  input  logic [WORD_SIZE-1:0]  iKey0,
  input  logic [WORD_SIZE-1:0]  iKey1,
  input  logic [WORD_SIZE-1:0]  iKey2,
  input  logic [WORD_SIZE-1:0]  iKey3,
  output logic [ADDR_WIDTH-1:0] oData_address,
  input  logic [WORD_SIZE-1:0]  iData,
  output logic [WORD_SIZE-1:0]  oData,
  output logic                  oData_we,
  output logic                  oBusy,
  output logic                  oDone
);

  // Decrypt starts from the sum the encrypt side ends with
  localparam logic [31:0] SUM_INIT = 32'(DELTA * 32'(ROUNDS));
  localparam logic [7:0]  LAST_RND = 8'(ROUNDS - 1);

  tea_state_e            state_q;
  logic [WORD_SIZE-1:0]  v0_q;
  logic [WORD_SIZE-1:0]  v1_q;
  logic [31:0]           sum_q;
  logic [7:0]            rnd_q;
  logic                  dec_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_p1;

  logic                  upd_v0;
  logic [31:0]           hr_upd;
  logic [31:0]           hr_src;
  logic [31:0]           hr_sum;
  logic [31:0]           hr_ka;
  logic [31:0]           hr_kb;
  logic [31:0]           half_d;

  assign base_p1 = base_q + ADDR_WIDTH'(1);

  // Operand mux for the shared half-round: the v0 update (k0/k1) is HALF_A when
  // encrypting and HALF_B when decrypting; encrypt HALF_A sees the pre-incremented sum
  always_comb begin
    upd_v0 = (state_q == ST_HALF_A) ^ dec_q;
    hr_upd = upd_v0 ? v0_q  : v1_q;
    hr_src = upd_v0 ? v1_q  : v0_q;
    hr_ka  = upd_v0 ? iKey0 : iKey2;
    hr_kb  = upd_v0 ? iKey1 : iKey3;
    hr_sum = ((state_q == ST_HALF_A) && !dec_q) ? (sum_q + DELTA) : sum_q;
  end

  tea_half_round u_half (
    .v_upd_i (hr_upd),
    .v_src_i (hr_src),
    .sum_i   (hr_sum),
    .ka_i    (hr_ka),
    .kb_i    (hr_kb),
    .sub_i   (dec_q),
    .v_new_o (half_d)
  );

  // Main FSM with registered outputs; iStart low returns to IDLE from anywhere
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      v0_q          <= '0;
      v1_q          <= '0;
      sum_q         <= '0;
      rnd_q         <= '0;
      dec_q         <= 1'b0;
      base_q        <= '0;
      oKeyStart     <= 1'b0;
      oData_address <= '0;
      oData         <= '0;
      oData_we      <= 1'b0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
    end else if (!iStart) begin
      state_q       <= ST_IDLE;
      rnd_q         <= '0;
      oKeyStart     <= 1'b0;
      oData_address <= '0;
      oData         <= '0;
      oData_we      <= 1'b0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
    end else begin
      oData_we <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dec_q     <= iDecrypt;
          base_q    <= iBase_addr;
          sum_q     <= iDecrypt ? SUM_INIT : 32'd0;
          rnd_q     <= '0;
          oKeyStart <= 1'b1;
          oBusy     <= 1'b1;
          state_q   <= ST_LOAD_KEY;
        end
        ST_LOAD_KEY: begin
          if (iKeyDone) begin
            oData_address <= base_q;
            state_q       <= ST_RD_V0_A;
          end
        end
        ST_RD_V0_A: state_q <= ST_RD_V0_D;
        ST_RD_V0_D: begin
          v0_q          <= iData;
          oData_address <= base_p1;
          state_q       <= ST_RD_V1_A;
        end
        ST_RD_V1_A: state_q <= ST_RD_V1_D;
        ST_RD_V1_D: begin
          v1_q    <= iData;
          state_q <= ST_HALF_A;
        end
        ST_HALF_A: begin
          if (dec_q) begin
            v1_q <= half_d;
          end else begin
            v0_q  <= half_d;
            sum_q <= sum_q + DELTA;
          end
          state_q <= ST_HALF_B;
        end
        ST_HALF_B: begin
          if (dec_q) begin
            v0_q  <= half_d;
            sum_q <= sum_q - DELTA;
          end else begin
            v1_q <= half_d;
          end
          rnd_q <= rnd_q + 8'd1;
          if (rnd_q == LAST_RND) begin
            // v0 may be updated on this same edge when decrypting
            oData_address <= base_q;
            oData         <= dec_q ? half_d : v0_q;
            oData_we      <= 1'b1;
            state_q       <= ST_WR_V0;
          end else begin
            state_q <= ST_HALF_A;
          end
        end
        ST_WR_V0: begin
          oData_address <= base_p1;
          oData         <= v1_q;
          oData_we      <= 1'b1;
          state_q       <= ST_WR_V1;
        end
        ST_WR_V1: begin
          oBusy   <= 1'b0;
          oDone   <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_ctrl.sv
// Directed bench for tea_ctrl with a 1-cycle-latency RAM model and a reference TEA model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tea_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iStart = 1'b0;
  logic        iDecrypt = 1'b0;
  logic [7:0]  iBase_addr = 8'h00;
  logic        oKeyStart;
  logic        iKeyDone = 1'b0;
  logic [31:0] iKey0 = '0;
  logic [31:0] iKey1 = '0;
  logic [31:0] iKey2 = '0;
  logic [31:0] iKey3 = '0;
  logic [7:0]  oData_address;
  logic [31:0] iData;
  logic [31:0] oData;
  logic        oData_we;
  logic        oBusy;
  logic        oDone;

  logic [31:0] mem [0:255];
  int          we_cnt = 0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h00;
  logic [31:0] pl_dat = '0;

  int checks = 0;
  int failures = 0;

  tea_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .iStart        (iStart),
    .iDecrypt      (iDecrypt),
    .iBase_addr    (iBase_addr),
    .oKeyStart     (oKeyStart),
    .iKeyDone      (iKeyDone),
    .iKey0         (iKey0),
    .iKey1         (iKey1),
    .iKey2         (iKey2),
    .iKey3         (iKey3),
    .oData_address (oData_address),
    .iData         (iData),
    .oData         (oData),
    .oData_we      (oData_we),
    .oBusy         (oBusy),
    .oDone         (oDone)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data one cycle after address, read-before-write
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    if (oData_we) begin
      mem[oData_address] <= oData;
      we_cnt <= we_cnt + 1;
    end
    iData <= mem[oData_address];
  end

  function automatic logic [63:0] m_enc(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] k0, input logic [31:0] k1,
                                        input logic [31:0] k2, input logic [31:0] k3);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < 32; i++) begin
      s = s + 32'h9E3779B9;
      a = a + ((((b << 4) + k0)) ^ (b + s) ^ ((b >> 5) + k1));
      b = b + ((((a << 4) + k2)) ^ (a + s) ^ ((a >> 5) + k3));
    end
    return {a, b};
  endfunction

  function automatic logic [63:0] m_dec(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] k0, input logic [31:0] k1,
                                        input logic [31:0] k2, input logic [31:0] k3);
    logic [31:0] s;
    s = 32'hC6EF3720;
    for (int i = 0; i < 32; i++) begin
      b = b - ((((a << 4) + k2)) ^ (a + s) ^ ((a >> 5) + k3));
      a = a - ((((b << 4) + k0)) ^ (b + s) ^ ((b >> 5) + k1));
      s = s - 32'h9E3779B9;
    end
    return {a, b};
  endfunction

  task automatic preload(input logic [7:0] addr, input logic [31:0] dat);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = addr; pl_dat = dat;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Runs one op; iKeyDone rises kd cycles after iStart. lat counts from the
  // iKeyDone edge (kd=0: counted from iStart). Config inputs are scrambled after start.
  task automatic run_op(input logic dec, input logic [7:0] base,
                        input logic [31:0] k0, input logic [31:0] k1,
                        input logic [31:0] k2, input logic [31:0] k3,
                        input int kd, input bit hold, output int lat, output int wes);
    int cyc;
    int w0;
    @(negedge clk);
    w0 = we_cnt;
    iDecrypt = dec; iBase_addr = base;
    iKey0 = k0; iKey1 = k1; iKey2 = k2; iKey3 = k3;
    iKeyDone = 1'b0; iStart = 1'b1;
    cyc = 0;
    while (!oDone && cyc < 400) begin
      if (cyc == kd) iKeyDone = 1'b1;
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        iDecrypt = ~dec;
        iBase_addr = base ^ 8'h5A;
      end
    end
    checks++;
    if (!oDone) begin
      failures++;
      $display("FAIL run_timeout oDone=%0b after %0d cycles, required 1", oDone, cyc);
    end
    lat = cyc - kd;
    wes = we_cnt - w0;
    if (!hold) begin
      iStart = 1'b0; iKeyDone = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #3;
    checks++;
    if ({oKeyStart, oBusy, oDone, oData_we} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b required=0000", {oKeyStart, oBusy, oDone, oData_we});
    end
    checks++;
    if ({oData_address, oData} !== 40'h0) begin
      failures++; $display("FAIL reset_bus got=%h required=0", {oData_address, oData});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({oKeyStart, oBusy, oDone} !== 3'b000) begin
      failures++; $display("FAIL idle_flags got=%b required=000", {oKeyStart, oBusy, oDone});
    end
  endtask

  task automatic test_enc_zero();
    int lat, wes;
    preload(8'h10, 32'h0);
    preload(8'h11, 32'h0);
    @(negedge clk);
    iStart = 1'b1; iDecrypt = 1'b0; iBase_addr = 8'h10;
    @(negedge clk);
    checks++;
    if ({oKeyStart, oBusy, oDone} !== 3'b110) begin
      failures++; $display("FAIL load_key_flags got=%b required=110", {oKeyStart, oBusy, oDone});
    end
    iStart = 1'b0;
    @(negedge clk);
    run_op(1'b0, 8'h10, 0, 0, 0, 0, 5, 1'b0, lat, wes);
    checks++;
    if (lat != 71) begin failures++; $display("FAIL enc_latency got=%0d required=71", lat); end
    checks++;
    if (mem[8'h10] !== 32'h41EA3A0A) begin failures++; $display("FAIL enc_v0 got=%h required=41ea3a0a", mem[8'h10]); end
    checks++;
    if (mem[8'h11] !== 32'h94BAA940) begin failures++; $display("FAIL enc_v1 got=%h required=94baa940", mem[8'h11]); end
    checks++;
    if (oDone !== 1'b0) begin failures++; $display("FAIL done_clear got=%b required=0", oDone); end
  endtask

  task automatic test_dec_zero();
    int lat, wes;
    run_op(1'b1, 8'h10, 0, 0, 0, 0, 3, 1'b0, lat, wes);
    checks++;
    if ({mem[8'h10], mem[8'h11]} !== 64'h0) begin
      failures++; $display("FAIL dec_zero got=%h required=0", {mem[8'h10], mem[8'h11]});
    end
    checks++;
    if (wes != 2) begin failures++; $display("FAIL dec_we_pulses got=%0d required=2", wes); end
    checks++;
    if (lat != 71) begin failures++; $display("FAIL dec_latency got=%0d required=71", lat); end
  endtask

  task automatic test_random();
    int lat, wes, kd;
    logic [31:0] k [4];
    logic [31:0] a, b;
    logic [7:0]  base;
    logic [63:0] exp_ct;
    for (int it = 0; it < 20; it++) begin
      for (int j = 0; j < 4; j++) k[j] = $urandom;
      a = $urandom; b = $urandom;
      base = 8'($urandom_range(0, 255));
      kd = $urandom_range(0, 6);
      exp_ct = m_enc(a, b, k[0], k[1], k[2], k[3]);
      preload(base, a);
      preload(base + 8'd1, b);
      run_op(1'b0, base, k[0], k[1], k[2], k[3], kd, 1'b0, lat, wes);
      checks++;
      if ({mem[base], mem[base + 8'd1]} !== exp_ct) begin
        failures++; $display("FAIL rand_enc[%0d] got=%h required=%h", it, {mem[base], mem[base + 8'd1]}, exp_ct);
      end
      checks++;
      if (lat != ((kd == 0) ? 72 : 71)) begin
        failures++; $display("FAIL rand_latency[%0d] got=%0d required=%0d", it, lat, (kd == 0) ? 72 : 71);
      end
      run_op(1'b1, base, k[0], k[1], k[2], k[3], kd, 1'b0, lat, wes);
      checks++;
      if ({mem[base], mem[base + 8'd1]} !== {a, b}) begin
        failures++; $display("FAIL rand_dec[%0d] got=%h required=%h", it, {mem[base], mem[base + 8'd1]}, {a, b});
      end
    end
    checks++;
    if (m_dec(32'h41EA3A0A, 32'h94BAA940, 0, 0, 0, 0) !== 64'h0) begin
      failures++; $display("FAIL model_dec got=%h required=0", m_dec(32'h41EA3A0A, 32'h94BAA940, 0, 0, 0, 0));
    end
  endtask

  task automatic test_abort();
    int w0;
    preload(8'h20, 32'hA5A5A5A5);
    preload(8'h21, 32'h5A5A5A5A);
    @(negedge clk);
    w0 = we_cnt;
    iDecrypt = 1'b0; iBase_addr = 8'h20; iKey0 = 32'h1; iKey1 = 32'h2; iKey2 = 32'h3; iKey3 = 32'h4;
    iStart = 1'b1;
    repeat (2) @(negedge clk);
    iKeyDone = 1'b1;
    // negedge after the 26th edge from iKeyDone: HALF_B of round 10 (0-based)
    repeat (26) @(negedge clk);
    checks++;
    if (oBusy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b required=1", oBusy); end
    iStart = 1'b0; iKeyDone = 1'b0;
    @(negedge clk);
    checks++;
    if ({oKeyStart, oBusy, oDone, oData_we} !== 4'b0000) begin
      failures++; $display("FAIL abort_flags got=%b required=0000", {oKeyStart, oBusy, oDone, oData_we});
    end
    repeat (80) @(negedge clk);
    checks++;
    if (we_cnt != w0) begin failures++; $display("FAIL abort_no_write got=%0d required=%0d", we_cnt, w0); end
    checks++;
    if ({mem[8'h20], mem[8'h21]} !== 64'hA5A5A5A5_5A5A5A5A) begin
      failures++; $display("FAIL abort_mem got=%h required=a5a5a5a55a5a5a5a", {mem[8'h20], mem[8'h21]});
    end
  endtask

  task automatic test_async_rst();
    int cyc, w0;
    logic [63:0] exp_ct;
    exp_ct = m_enc(32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEBABE, 32'h13579BDF);
    preload(8'h30, 32'h01234567);
    preload(8'h31, 32'h89ABCDEF);
    @(negedge clk);
    iDecrypt = 1'b0; iBase_addr = 8'h30;
    iKey0 = 32'hDEADBEEF; iKey1 = 32'h0BADF00D; iKey2 = 32'hCAFEBABE; iKey3 = 32'h13579BDF;
    iStart = 1'b1;
    @(negedge clk);
    iKeyDone = 1'b1;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({oKeyStart, oBusy, oDone, oData_we} !== 4'b0000) begin
      failures++; $display("FAIL arst_flags got=%b required=0000", {oKeyStart, oBusy, oDone, oData_we});
    end
    checks++;
    if ({oData_address, oData} !== 40'h0) begin
      failures++; $display("FAIL arst_bus got=%h required=0", {oData_address, oData});
    end
    iKeyDone = 1'b0;
    #13 rst = 1'b1;
    w0 = we_cnt;
    repeat (3) @(negedge clk);
    iKeyDone = 1'b1;
    cyc = 0;
    while (!oDone && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 71) begin failures++; $display("FAIL arst_rerun_latency got=%0d required=71", cyc); end
    checks++;
    if ({mem[8'h30], mem[8'h31]} !== exp_ct) begin
      failures++; $display("FAIL arst_rerun got=%h required=%h", {mem[8'h30], mem[8'h31]}, exp_ct);
    end
    checks++;
    if (we_cnt - w0 != 2) begin failures++; $display("FAIL arst_we_pulses got=%0d required=2", we_cnt - w0); end
    iStart = 1'b0; iKeyDone = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_base_wrap_hold();
    int lat, wes, w0;
    logic [63:0] exp_ct;
    exp_ct = m_enc(32'hFEEDFACE, 32'h00C0FFEE, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    preload(8'hFF, 32'hFEEDFACE);
    preload(8'h00, 32'h00C0FFEE);
    preload(8'h01, 32'h77777777);
    run_op(1'b0, 8'hFF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4, 1'b1, lat, wes);
    w0 = we_cnt;
    checks++;
    if ({mem[8'hFF], mem[8'h00]} !== exp_ct) begin
      failures++; $display("FAIL wrap_result got=%h required=%h", {mem[8'hFF], mem[8'h00]}, exp_ct);
    end
    checks++;
    if (mem[8'h01] !== 32'h77777777) begin failures++; $display("FAIL wrap_no_spill got=%h required=77777777", mem[8'h01]); end
    repeat (150) @(negedge clk);
    checks++;
    if ({oDone, oBusy, oKeyStart} !== 3'b101) begin
      failures++; $display("FAIL hold_done_flags got=%b required=101", {oDone, oBusy, oKeyStart});
    end
    checks++;
    if (we_cnt != w0) begin failures++; $display("FAIL hold_no_rerun got=%0d required=%0d", we_cnt, w0); end
    iStart = 1'b0; iKeyDone = 1'b0;
    @(negedge clk);
    checks++;
    if ({oDone, oKeyStart} !== 2'b00) begin failures++; $display("FAIL done_release got=%b required=00", {oDone, oKeyStart}); end
  endtask

  initial begin
    test_reset();
    test_enc_zero();
    test_dec_zero();
    test_random();
    test_abort();
    test_async_rst();
    test_base_wrap_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
